// File: rtl/ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares one single-port image RAM between two requesters: port A (processor
// core) and port B (image loader). Each granted access is sequenced onto the
// RAM address/control/bidirectional data bus. When both requesters contend,
// the arbiter alternates between them (round-robin).
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata    port A request (fields sampled at grant)
//   a_done, a_rdata              port A completion pulse and read data
//   b_*                          same as port A, for port B
//   ram_address                  RAM address
//   ram_control                  {enable, write, read}: 000 idle, 110 write, 101 read
//   ram_data                     RAM data bus; driven only during a write cycle
// -----------------------------------------------------------------------------
module ram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [2:0]        ram_control,
  inout  wire  [DATA_W-1:0] ram_data
);

  typedef enum logic [1:0] {IDLE, WR, RD, RD_CAP} state_t;

  localparam logic [2:0] CTRL_IDLE = 3'b000;
  localparam logic [2:0] CTRL_WR   = 3'b110;
  localparam logic [2:0] CTRL_RD   = 3'b101;

  state_t              state_q;
  logic                owner_b_q;       // 1: current access belongs to port B
  logic                last_grant_b_q;  // 1: most recent grant went to port B
  logic [DATA_W-1:0]   wdata_q;
  logic                drive_q;         // registered bus output enable
  logic [2:0]          ctrl_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                a_done_q, b_done_q;
  logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;

  logic                a_elig_d, b_elig_d;
  logic                grant_valid_d, grant_b_d;
  logic                sel_we_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_wdata_d;

  // A requester whose done is high this cycle is still holding req from the
  // finished access, so it is masked out to avoid a duplicate grant.
  always_comb begin
    a_elig_d      = a_req & ~a_done_q;
    b_elig_d      = b_req & ~b_done_q;
    grant_valid_d = a_elig_d | b_elig_d;
    // Under contention, favour whichever port did not win last time.
    grant_b_d     = b_elig_d & (~a_elig_d | ~last_grant_b_q);
    sel_we_d      = grant_b_d ? b_we    : a_we;
    sel_addr_d    = grant_b_d ? b_addr  : a_addr;
    sel_wdata_d   = grant_b_d ? b_wdata : a_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      owner_b_q      <= 1'b0;
      last_grant_b_q <= 1'b1;
      wdata_q        <= '0;
      drive_q        <= 1'b0;
      ctrl_q         <= CTRL_IDLE;
      addr_q         <= '0;
      a_done_q       <= 1'b0;
      b_done_q       <= 1'b0;
      a_rdata_q      <= '0;
      b_rdata_q      <= '0;
    end else begin
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid_d) begin
            owner_b_q      <= grant_b_d;
            last_grant_b_q <= grant_b_d;
            addr_q         <= sel_addr_d;
            wdata_q        <= sel_wdata_d;
            if (sel_we_d) begin
              state_q <= WR;
              ctrl_q  <= CTRL_WR;
              drive_q <= 1'b1;
            end else begin
              state_q <= RD;
              ctrl_q  <= CTRL_RD;
              drive_q <= 1'b0;
            end
          end else begin
            ctrl_q  <= CTRL_IDLE;
            drive_q <= 1'b0;
          end
        end
        WR: begin
          state_q <= IDLE;
          ctrl_q  <= CTRL_IDLE;
          drive_q <= 1'b0;
          if (owner_b_q) b_done_q <= 1'b1;
          else           a_done_q <= 1'b1;
        end
        RD: begin
          // Command stays at 101 for a second cycle to give the RAM time.
          state_q <= RD_CAP;
        end
        RD_CAP: begin
          state_q <= IDLE;
          ctrl_q  <= CTRL_IDLE;
          if (owner_b_q) begin
            b_rdata_q <= ram_data;
            b_done_q  <= 1'b1;
          end else begin
            a_rdata_q <= ram_data;
            a_done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ctrl_q  <= CTRL_IDLE;
          drive_q <= 1'b0;
        end
      endcase
    end
  end

  assign ram_data    = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign ram_control = ctrl_q;
  assign ram_address = addr_q;
  assign a_done      = a_done_q;
  assign b_done      = b_done_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_port_arbiter
//
// Self-checking bench for ram_port_arbiter. Contains a behavioural RAM on the
// shared bus (read data appears in the second cycle of a read command), a
// reference memory image, and a scoreboard: each issued access pushes its
// expected response onto a per-port queue, and a monitor pops and compares on
// every done pulse.
// -----------------------------------------------------------------------------
module tb_ram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_done, b_done;
  logic [15:0] a_rdata, b_rdata;
  logic [7:0]  ram_address;
  logic [2:0]  ram_control;
  wire  [15:0] ram_data;

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(b_done), .b_rdata(b_rdata),
    .ram_address(ram_address), .ram_control(ram_control), .ram_data(ram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return {a ^ 8'hA5, a};
  endfunction

  // ---------------- behavioural RAM on the bus ----------------
  logic [15:0] mem [256];
  logic        written [256];
  logic [2:0]  ctrl_prev = 3'b000;
  logic [15:0] ram_rd_val;
  logic        ram_rd_drive;

  function automatic logic [15:0] ram_word(input logic [7:0] a);
    return written[a] ? mem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    ctrl_prev <= ram_control;
    if (ram_control == 3'b110) begin
      mem[ram_address]     <= ram_data;
      written[ram_address] <= 1'b1;
    end
  end

  assign ram_rd_val   = ram_word(ram_address);
  assign ram_rd_drive = (ram_control == 3'b101) && (ctrl_prev == 3'b101);
  assign ram_data     = ram_rd_drive ? ram_rd_val : 16'hzzzz;

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic        we;
    logic [15:0] rdata;
  } exp_t;

  logic [15:0] ref_mem [256];
  exp_t        exp_a[$], exp_b[$];
  int          order_q[$];
  logic [15:0] a_hold, b_hold;  // rdata each port must currently show
  bit          sb_en = 1'b0;

  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      check("ctrl_legal", {31'd0, (ram_control == 3'b000) || (ram_control == 3'b110)
                                 || (ram_control == 3'b101)}, 32'd1);
      if (a_done) begin
        check("a_exp_pending", {31'd0, exp_a.size() != 0}, 32'd1);
        if (exp_a.size() != 0) begin
          exp_t e;
          e = exp_a.pop_front();
          if (!e.we) a_hold = e.rdata;
        end
        order_q.push_back(0);
      end
      if (b_done) begin
        check("b_exp_pending", {31'd0, exp_b.size() != 0}, 32'd1);
        if (exp_b.size() != 0) begin
          exp_t e;
          e = exp_b.pop_front();
          if (!e.we) b_hold = e.rdata;
        end
        order_q.push_back(1);
      end
      check("a_rdata", {16'd0, a_rdata}, {16'd0, a_hold});
      check("b_rdata", {16'd0, b_rdata}, {16'd0, b_hold});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (2) tick();
    rst_n  = 1'b1;
    a_hold = 16'h0;
    b_hold = 16'h0;
    tick();
  endtask

  // Issue one access, record its expected outcome, wait (bounded) for done.
  // req is left high so the caller may chain the next request immediately.
  task automatic sb_access(input bit pb, input bit we, input logic [7:0] addr,
                           input logic [15:0] wd);
    exp_t e;
    bit   seen;
    e.we    = we;
    e.rdata = we ? 16'h0 : ref_mem[addr];
    if (we) ref_mem[addr] = wd;
    if (pb) begin
      exp_b.push_back(e);
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      exp_a.push_back(e);
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pb ? b_done : a_done) begin
        seen = 1'b1;
        break;
      end
    end
    check(pb ? "b_done_timeout" : "a_done_timeout", {31'd0, seen}, 32'd1);
  endtask

  // Port A uses even addresses, port B odd, so expected read data is fixed at issue.
  task automatic port_loop(input bit pb, input int n, input int gap_max);
    for (int k = 0; k < n; k++) begin
      logic [7:0] addr;
      int         gap;
      addr = {7'($urandom_range(0, 127)), pb};
      sb_access(pb, 1'($urandom_range(0, 1)), addr, 16'($urandom));
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      if (gap > 0 || k == n - 1) begin
        if (pb) b_req = 1'b0;
        else    a_req = 1'b0;
        repeat (gap) tick();
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    a_hold = 0; b_hold = 0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = init_val(8'(i));
    end

    // Reset state
    repeat (2) tick();
    check("rst_ctrl", {29'd0, ram_control}, 32'd0);
    check("rst_addr", {24'd0, ram_address}, 32'd0);
    check("rst_done", {30'd0, a_done, b_done}, 32'd0);
    check("rst_rdata", {a_rdata, b_rdata}, 32'd0);
    rst_n = 1'b1;
    tick();

    // A write 01 <= 00C0
    a_req = 1; a_we = 1; a_addr = 8'h01; a_wdata = 16'h00C0;
    ref_mem[8'h01] = 16'h00C0;
    tick();
    check("wr_ctrl", {29'd0, ram_control}, 32'h6);
    check("wr_addr", {24'd0, ram_address}, 32'h01);
    check("wr_bus", {16'd0, ram_data}, 32'h00C0);
    check("wr_done_early", {31'd0, a_done}, 32'd0);
    tick();
    check("wr_done", {31'd0, a_done}, 32'd1);
    check("wr_ctrl_idle", {29'd0, ram_control}, 32'd0);
    a_req = 0;
    tick();
    check("wr_done_once", {31'd0, a_done}, 32'd0);
    check("wr_ram", {16'd0, ram_word(8'h01)}, 32'h00C0);

    // A read back 01
    a_req = 1; a_we = 0; a_addr = 8'h01; a_wdata = 16'hFFFF;
    tick();
    check("rd_ctrl", {29'd0, ram_control}, 32'h5);
    check("rd_addr", {24'd0, ram_address}, 32'h01);
    tick();
    check("rdcap_ctrl", {29'd0, ram_control}, 32'h5);
    check("rdcap_done_early", {31'd0, a_done}, 32'd0);
    tick();
    check("rd_done", {31'd0, a_done}, 32'd1);
    check("rd_data", {16'd0, a_rdata}, 32'h00C0);
    check("rd_ctrl_idle", {29'd0, ram_control}, 32'd0);
    a_req = 0;
    tick();
    check("rd_hold", {16'd0, a_rdata}, 32'h00C0);
    check("rd_done_once", {31'd0, a_done}, 32'd0);

    // Reset in the middle of a B read
    b_req = 1; b_we = 0; b_addr = 8'h33;
    tick();
    tick();
    check("b_rdcap_ctrl", {29'd0, ram_control}, 32'h5);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {29'd0, ram_control}, 32'd0);
    check("midrst_b_done", {31'd0, b_done}, 32'd0);
    check("midrst_b_rdata", {16'd0, b_rdata}, 32'd0);
    b_req = 0;
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_no_done", {31'd0, b_done}, 32'd0);
    b_req = 1; b_we = 0; b_addr = 8'h33;
    repeat (3) tick();
    check("b_reread_done", {31'd0, b_done}, 32'd1);
    check("b_reread_data", {16'd0, b_rdata}, {16'd0, init_val(8'h33)});
    b_req = 0;
    tick();

    // B write whose request and fields change right after grant
    b_req = 1; b_we = 1; b_addr = 8'h44; b_wdata = 16'hBEEF;
    ref_mem[8'h44] = 16'hBEEF;
    tick();
    check("drop_wr_addr", {24'd0, ram_address}, 32'h44);
    check("drop_wr_bus", {16'd0, ram_data}, 32'hBEEF);
    b_req = 0; b_we = 0; b_addr = 8'h55; b_wdata = 16'h1234;
    tick();
    check("drop_done", {31'd0, b_done}, 32'd1);
    tick();
    check("drop_done_once", {31'd0, b_done}, 32'd0);
    check("drop_ram", {16'd0, ram_word(8'h44)}, 32'hBEEF);
    check("drop_ram_other", {16'd0, ram_word(8'h55)}, {16'd0, init_val(8'h55)});

    // Simultaneous writes straight after reset: A first, B in A's done cycle
    do_reset();
    a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 16'h1111;
    b_req = 1; b_we = 1; b_addr = 8'h20; b_wdata = 16'h2222;
    ref_mem[8'h10] = 16'h1111;
    ref_mem[8'h20] = 16'h2222;
    tick();
    check("sim_first_addr", {24'd0, ram_address}, 32'h10);
    tick();
    check("sim_a_done", {30'd0, a_done, b_done}, 32'h2);
    a_req = 0;
    tick();
    check("sim_second_addr", {24'd0, ram_address}, 32'h20);
    check("sim_second_ctrl", {29'd0, ram_control}, 32'h6);
    tick();
    check("sim_b_done", {30'd0, a_done, b_done}, 32'h1);
    b_req = 0;
    tick();
    check("sim_ram_a", {16'd0, ram_word(8'h10)}, 32'h1111);
    check("sim_ram_b", {16'd0, ram_word(8'h20)}, 32'h2222);

    // Continuous contention: 3 accesses per port, re-requesting immediately
    sb_en = 1'b1;
    order_q.delete();
    fork
      port_loop(1'b0, 3, 0);
      port_loop(1'b1, 3, 0);
    join
    tick();
    check("order_len", order_q.size(), 32'd6);
    for (int k = 0; k < 6 && k < order_q.size(); k++) begin
      check("grant_order", order_q[k], k % 2);
    end

    // Randomized traffic with idle gaps
    fork
      port_loop(1'b0, 40, 3);
      port_loop(1'b1, 40, 3);
    join
    repeat (4) tick();
    sb_en = 1'b0;
    check("a_queue_empty", exp_a.size(), 32'd0);
    check("b_queue_empty", exp_b.size(), 32'd0);
    for (int i = 0; i < 256; i++) begin
      check("ram_image", {16'd0, ram_word(8'(i))}, {16'd0, ref_mem[i]});
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 16-bit image RAM between two requesters: port A (processor core) and port B (image loader).
- Sequences each access onto the RAM's address, control_signal and bidirectional data bus.
- Arbitrates round-robin when both requesters contend, and returns read data or write completion to the owning requester.
- Sits between the core/loader and the RAM instance.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_req  input  1  port A access request; held high until a_done.
- a_we  input  1  port A: 1 = write, 0 = read; sampled at grant.
- a_addr  input  ADDR_W  port A address; sampled at grant.
- a_wdata  input  DATA_W  port A write data; sampled at grant.
- a_done  output  1  one-cycle pulse: port A access complete.
- a_rdata  output  DATA_W  port A read data; valid while a_done is high, held until the next A read.
- b_req, b_we, b_addr, b_wdata, b_done, b_rdata: identical to the A ports, for port B.
- ram_address  output  ADDR_W  RAM address.
- ram_control  output  3  RAM control_signal.
  - bit2 = enable.
  - bit1 = write (controller drives bus).
  - bit0 = read.
- ram_data  inout  DATA_W  RAM data bus; driven only in WR state, otherwise high-Z.

Behaviour:
- Reset values (async, rst_n low):
  - state = IDLE.
  - ram_control = 3'b000, ram_address = 0, ram_data = Z.
  - a_done = b_done = 0, a_rdata = b_rdata = 0.
  - last_grant = B, so A wins the first contention.
  - Reset mid-transaction abandons the access; no done pulse is issued.
- Control encodings:
  - IDLE: 3'b000.
  - Write: 3'b110.
  - Read: 3'b101.
  - No other codes are ever emitted.
- FSM states: IDLE, WR, RD, RD_CAP.
- IDLE:
  - Evaluate eligible requests. A requester is ineligible in the cycle its own done is high, so it must drop req on seeing done.
  - One eligible requester: grant it.
  - Both eligible: grant the one not equal to last_grant.
  - On grant: latch owner, we, addr and wdata; update last_grant; next state is WR if we=1, RD if we=0.
  - No request: stay in IDLE, outputs idle.
- WR (1 cycle):
  - ram_control = 110, ram_address = latched addr, ram_data = latched wdata.
  - Next state IDLE; owner's done pulses high in that IDLE cycle.
- RD (1 cycle):
  - ram_control = 101, ram_address = latched addr, ram_data = Z.
  - Next state RD_CAP.
- RD_CAP (1 cycle):
  - ram_control = 101, address held.
  - At the closing edge, ram_data is captured into the owner's rdata.
  - Next state IDLE; owner's done pulses high with rdata valid.
  - The RAM must present read data within one cycle of the 101 command.
- Latency from grant-cycle edge to done:
  - Write: 2 cycles.
  - Read: 3 cycles.
  - Maximum throughput: one write per 2 cycles, one read per 3 cycles, with back-to-back grants allowed from the IDLE cycle that carries done.
- Request deassertion after grant is ignored; the access completes and done still pulses.
- Address, we and wdata changes after grant have no effect.
- The non-owner's rdata never changes during the owner's access.
- The bus output enable is registered from state; ram_data is never driven in IDLE, RD or RD_CAP, so there is no contention with the RAM.
- ram_address holds its last value in IDLE; it is not observable because control is 000.

Test Plan:
- Reset then A write:
  - Stimulus: a_req=1, a_we=1, a_addr=8'h01, a_wdata=16'h00C0.
  - Required: next cycle ram_control=110, ram_address=01, ram_data=00C0 for one cycle; a_done pulses one cycle later; then control returns to 000 with bus Z.
- A read back:
  - Stimulus: a_addr=8'h01, a_we=0.
  - Required: RD then RD_CAP with control=101 and bus Z from the controller; a_done pulses with a_rdata=16'h00C0.
- Simultaneous requests from reset:
  - Stimulus: A writes 8'h10 = 16'h1111; B writes 8'h20 = 16'h2222.
  - Required: A granted first, B granted in A's done cycle; order A, B; RAM holds both values.
- Continuous contention:
  - Stimulus: both requesters re-request immediately after each done, for 6 accesses.
  - Required: grants alternate A, B, A, B, A, B.
- Reset mid-read:
  - Stimulus: rst_n low during RD_CAP of a B read.
  - Required: control=000 and bus Z immediately; no b_done; b_rdata=0; after release, a fresh B read completes normally.
- Request dropped after grant:
  - Stimulus: b_req falls in the cycle after grant of a write.
  - Required: write still reaches the RAM and b_done still pulses once.
